// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for the write and read ports of a dual-port RAM.
// Define RAM_PORT_ARBITER_BYPASS_EN to return write-first data on same-address collisions.
module ram_port_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      wr_req,
    input  logic [2*AW-1:0] wr_addr,
    input  logic [2*DW-1:0] wr_data,
    output logic [1:0]      wr_gnt,
    input  logic [1:0]      rd_req,
    input  logic [2*AW-1:0] rd_addr,
    output logic [1:0]      rd_gnt,
    output logic            rd_valid,
    output logic            rd_id,
    output logic [DW-1:0]   rd_data,
    output logic            ram_we,
    output logic [AW-1:0]   ram_waddr,
    output logic [DW-1:0]   ram_wdata,
    output logic            ram_re,
    output logic [AW-1:0]   ram_raddr,
    input  logic [DW-1:0]   ram_rdata
);

    // Pointer holds the index granted last; on contention the other requester wins.
    logic wr_ptr;
    logic rd_ptr;

    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        case (req)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return ptr ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // NOTE: every output gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        wr_gnt    = 2'b00;
        rd_gnt    = 2'b00;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        if (rst) begin
            wr_gnt = rr_pick(wr_req, wr_ptr);
            rd_gnt = rr_pick(rd_req, rd_ptr);
        end
        if (wr_gnt[0]) begin
            ram_waddr = wr_addr[0 +: AW];
            ram_wdata = wr_data[0 +: DW];
        end else if (wr_gnt[1]) begin
            ram_waddr = wr_addr[AW +: AW];
            ram_wdata = wr_data[DW +: DW];
        end
        if (rd_gnt[0]) begin
            ram_raddr = rd_addr[0 +: AW];
        end else if (rd_gnt[1]) begin
            ram_raddr = rd_addr[AW +: AW];
        end
    end

    assign ram_we = |wr_gnt;
    assign ram_re = |rd_gnt;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= 1'b1;
            rd_ptr   <= 1'b1;
            rd_valid <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            if (ram_we) wr_ptr <= wr_gnt[1];
            if (ram_re) rd_ptr <= rd_gnt[1];
            rd_valid <= ram_re;
            rd_id    <= rd_gnt[1];
        end
    end

`ifdef RAM_PORT_ARBITER_BYPASS_EN
    logic          byp_flag;
    logic [DW-1:0] byp_data;
    logic          byp_hit;

    assign byp_hit = ram_we && ram_re && (ram_raddr == ram_waddr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_flag <= 1'b0;
        end else begin
            byp_flag <= byp_hit;
        end
    end

    // NOTE: the data register needs no reset; it is only observed when byp_flag is set.
    always_ff @(posedge clk) begin
        if (byp_hit) byp_data <= ram_wdata;
    end

    assign rd_data = !rd_valid ? '0 : (byp_flag ? byp_data : ram_rdata);
`else
    assign rd_data = rd_valid ? ram_rdata : '0;
`endif

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 8x16 dual-port RAM.
- The RAM has independent write and read ports, a registered read output (one-cycle latency) and `we`/`re` strobes.
- This block shares the write port between two writers and the read port between two readers, and drives the RAM command signals.
- It returns read data tagged with the requester ID and tracks the RAM's one-cycle read latency.

Parameters:
- DW, 16, data width; must match the RAM.
- AW, 3, address width; must match the RAM (depth 2**AW).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- wr_req  in  2  per-writer request; bit i belongs to writer i.
- wr_addr  in  2*AW  writer addresses; writer i in bits [i*AW +: AW].
- wr_data  in  2*DW  writer data; writer i in bits [i*DW +: DW].
- wr_gnt  out  2  one-hot write grant, same cycle as the request.
- rd_req  in  2  per-reader request.
- rd_addr  in  2*AW  reader addresses, packed as for wr_addr.
- rd_gnt  out  2  one-hot read grant, same cycle as the request.
- rd_valid  out  1  read response valid.
- rd_id  out  1  requester index owning the current response.
- rd_data  out  DW  read response data.
- ram_we  out  1  to RAM `we`.
- ram_waddr  out  AW  to RAM `waddr`.
- ram_wdata  out  DW  to RAM `data`.
- ram_re  out  1  to RAM `re`.
- ram_raddr  out  AW  to RAM `raddr`.
- ram_rdata  in  DW  from RAM `out`.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_valid=0, rd_id=0.
  - Write and read round-robin pointers set to 1, so requester 0 wins the first contention.
  - All pending responses are dropped.
- Grants and RAM commands are combinational from the requests and the registered pointers. A transfer happens in cycle N when its gnt bit is 1; the requester holds req, addr and data stable until granted.
- Write arbitration:
  - Exactly one req bit set: that requester is granted.
  - Both bits set: grant the requester other than wr_ptr.
  - On any grant, wr_ptr <= granted index at the next edge; no grant leaves wr_ptr unchanged.
  - ram_we = |wr_gnt. ram_waddr and ram_wdata are muxed from the granted requester; with no grant they are 0.
- Read arbitration: identical scheme with its own rd_ptr, driving ram_re, ram_raddr and rd_gnt.
- Write and read sides are independent; one write and one read may be granted in the same cycle.
- Read latency:
  - Grant in cycle N → RAM registers the data at the end of cycle N.
  - In cycle N+1: rd_valid=1, rd_id=granted index, rd_data=ram_rdata.
  - rd_valid and rd_id are registered; rd_data is combinational from ram_rdata, qualified by rd_valid.
  - Back-to-back grants yield back-to-back responses, one per cycle, with no bubbles.
- Same-address read and write in one cycle: the RAM returns the old contents (read-before-write) unless the optional feature is enabled.
- Fairness: under continuous contention each side strictly alternates 0,1,0,1,…; the maximum wait is 1 cycle.
- Reset mid-operation:
  - A response due in the next cycle is discarded; rd_valid stays 0.
  - Grants are forced to 0 while rst=0.
  - The RAM contents are not touched by this block.
- Requests are don't-care while rst=0; the first grant is possible in the first cycle after rst deasserts.

Optional Feature:
- Macro: RAM_PORT_ARBITER_BYPASS_EN.
- Defined:
  - In a cycle where ram_re and ram_we are both 1 and ram_raddr==ram_waddr, register a bypass flag plus ram_wdata.
  - In the response cycle, rd_data = the registered write data instead of ram_rdata (write-first semantics).
  - Adds one AW-bit comparator, a 1-bit flag register and a DW-bit data register; the flag resets to 0.
- Undefined: no bypass logic; rd_data always equals ram_rdata (read-before-write).

Test Plan:
- Reset: rst=0 with both wr_req and rd_req =2'b11 → wr_gnt=rd_gnt=0 and rd_valid=0. After release, with both still requesting, first grants are wr_gnt=2'b01 and rd_gnt=2'b01.
- Single writer then reader: writer1 writes addr 5 data 16'hBEEF (wr_gnt=2'b10, ram_we=1); next cycle reader0 reads addr 5 → following cycle rd_valid=1, rd_id=0, rd_data=16'hBEEF.
- Contention: both writers request continuously for 6 cycles with distinct data → grants alternate 01,10,01,10,01,10; readback of both addresses shows the last data each writer wrote.
- Back-to-back reads: readers 0 and 1 request continuously at addrs 2 and 3, preloaded with 16'h1111 and 16'h2222 → rd_valid held 1; rd_id/rd_data alternate 0/1111, 1/2222 with 1-cycle latency.
- Collision: addr 4 holds 16'h0001; same cycle write 16'hA5A5 to addr 4 and read addr 4 → response 16'h0001 without the macro, 16'hA5A5 with RAM_PORT_ARBITER_BYPASS_EN.
- Reset mid-read: grant a read in cycle N, assert rst during cycle N+1 → rd_valid=0 immediately and the response is never presented after reset release.
